t05_stage_reporter: RTL and testbench
=====================================

// Module: t05_stage_reporter
// PURPOSE
//  Stage-side end of the pipeline controller handshake. Watches the controller's state_reg
//  (HISTO..SPI) and issues a 1-cycle start pulse to the active stage module. It collects that
//  module's done/error pulses, and drives the single finState/op_fin code pair the controller
//  waits on. Sits between the controller and the HISTO/FLV/HTREE/CBS/TRN/SPI modules.
//  Adds a per-stage watchdog.
// PARAMETERS
//  TIMEOUT_W       24       width of watchdog counter
//  TIMEOUT_CYCLES  2**22    cycles in RUN before forced error; 0 disables watchdog
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   reset, asynchronous, active-high
//  state_reg       in   4   controller state: 0 IDLE,1 HISTO,2 FLV,3 HTREE,4 CBS,5 TRN,6 SPI,7 ERROR,8 DONE
//  stage_done      in   6   1-cycle done pulses; bit0 HISTO .. bit5 SPI
//  htree_complete  in   1   HTREE final-merge (NULL+NULL) done pulse
//  mod_err         in   1   error pulse from any stage module
//  stage_start     out  6   1-cycle start pulse; bit k = stage code k+1
//  finState        out  4   0 IDLE_FIN,1 HFIN,2 FLV_FIN,3 HTREE_FIN,4 HTREE_FINISHED,5 CBS_FIN,6 TRN_FIN,7 SPI_FIN,8 ERROR_FIN
//  op_fin          out  4   0 IDLE_S,1 HIST_S,2 FLV_S,3 HTREE_S,4 CBS_S,5 TRN_S,6 SPI_S,7 ERROR_S
//  stage_busy      out  1   high while in LAUNCH or RUN
//  timeout         out  1   sticky; set on watchdog expiry, cleared when state_reg==IDLE
//  stray_done      out  1   sticky; done pulse for non-active stage, cleared when state_reg==IDLE
// BEHAVIOUR
//  Reset: all outputs 0, phase WAIT, prev_state=IDLE, watchdog=0. All outputs are registered.
//  prev_state register samples state_reg every cycle; change = (state_reg != prev_state).
//  Phases:
//   WAIT: on change to code 1..6 -> LAUNCH; stage_start[code-1]=1 for exactly one cycle.
//     Same edge clears finState/op_fin to 0.
//   LAUNCH (1 cycle) -> RUN. Done/err pulses are accepted in LAUNCH and in RUN.
//   RUN: watchdog increments, saturating.
//     Matching stage_done bit -> REPORT with finState=code, op_fin=code (HTREE: finState=3).
//     htree_complete while code==3 -> REPORT with finState=4, op_fin=3.
//     mod_err, or watchdog==TIMEOUT_CYCLES (when nonzero) -> ERR with finState=8, op_fin=7;
//     watchdog expiry also sets timeout.
//   REPORT: hold codes until change. Then clear both to 0 at that edge.
//     If the new state is 1..6 -> LAUNCH, else -> WAIT.
//   ERR: hold 8/7 until state_reg==IDLE or rst; later done pulses ignored.
//  Latency: state_reg change visible in cycle N -> stage_start high in cycle N+1.
//   Done pulse in cycle M -> finState/op_fin valid in cycle M+1.
//  Stale code: the old code stays visible for one cycle after state_reg changes.
//   This is harmless by construction: no state accepts another state's code.
//  Simultaneous events:
//   mod_err beats done.
//   htree_complete beats stage_done[2].
//   Change of state_reg in RUN aborts the stage: no report, watchdog cleared,
//   and a relaunch occurs if the new code is 1..6.
//  HTREE->FLV->HTREE loops: every re-entry is a change, so each entry gets a new start pulse.
//  stage_done bits other than the active stage's, or any done in WAIT/REPORT: ignored, sets stray_done.
//  state_reg 7/8 or >8: no launch; outputs in WAIT remain 0.
//  Watchdog cleared on every LAUNCH; width rule: TIMEOUT_CYCLES < 2**TIMEOUT_W.
// STRUCTURE
//  t05_ctrl_pkg: state_t, finState_t and op_fin_t enums with the codes above; phase enum for this block.
//   The controller and all stage modules import it.
//  Sub-module t05_stage_watchdog: clear, enable, saturating count, expired output.
// TESTING
//  1. HISTO (1) entered, stage_done[0] 5 cycles after start
//     -> start[0] single pulse; finState=1, op_fin=1 held until state_reg=2, then 0.
//  2. HTREE (3), stage_done[2] -> 3/3. Re-enter FLV then HTREE, pulse htree_complete
//     -> new start[2] on each entry; finState=4, op_fin=3.
//  3. mod_err and stage_done[4] in same cycle during CBS -> finState=8, op_fin=7;
//     held through state_reg=7; cleared when state_reg=0.
//  4. TIMEOUT_CYCLES=16, TRN entered, no done -> timeout=1 with 8/7 in cycle 17 after LAUNCH;
//     returning to IDLE clears timeout.
//  5. stage_done[5] during HISTO -> ignored, stray_done=1, finState stays 0.
//  6. rst asserted mid-RUN -> all outputs 0 immediately. After release with state_reg=1,
//     rst release alone does not launch; a change is required.

Source files
------------

// File: rtl/t05_ctrl_pkg.sv
// Shared controller/stage handshake codes, plus helpers for the stage reporter.
package t05_ctrl_pkg;

  // Controller state_reg codes.
  typedef enum logic [3:0] {
    StateIdle  = 4'd0,
    StateHisto = 4'd1,
    StateFlv   = 4'd2,
    StateHtree = 4'd3,
    StateCbs   = 4'd4,
    StateTrn   = 4'd5,
    StateSpi   = 4'd6,
    StateError = 4'd7,
    StateDone  = 4'd8
  } state_t;

  // finState codes the controller waits on.
  typedef enum logic [3:0] {
    FinIdle          = 4'd0,
    FinHist          = 4'd1,
    FinFlv           = 4'd2,
    FinHtree         = 4'd3,
    FinHtreeFinished = 4'd4,
    FinCbs           = 4'd5,
    FinTrn           = 4'd6,
    FinSpi           = 4'd7,
    FinError         = 4'd8
  } fin_state_t;

  // op_fin codes; stage codes map straight across.
  typedef enum logic [3:0] {
    OpIdle  = 4'd0,
    OpHist  = 4'd1,
    OpFlv   = 4'd2,
    OpHtree = 4'd3,
    OpCbs   = 4'd4,
    OpTrn   = 4'd5,
    OpSpi   = 4'd6,
    OpError = 4'd7
  } op_fin_t;

  // Reporter handshake phases.
  typedef enum logic [2:0] {
    PhWait,
    PhLaunch,
    PhRun,
    PhReport,
    PhErr
  } phase_t;

  // True for the six launchable stage codes.
  function automatic logic is_stage(input logic [3:0] code);
    return (code >= 4'd1) && (code <= 4'd6);
  endfunction

  // One-hot stage bit for a stage code; zero for anything else.
  function automatic logic [5:0] stage_onehot(input logic [3:0] code);
    if (is_stage(code)) return 6'b000001 << (code - 4'd1);
    return 6'b000000;
  endfunction

  // finState for a normal stage completion. HTREE_FINISHED sits between HTREE and CBS,
  // so CBS/TRN/SPI land one code above their stage code.
  function automatic logic [3:0] stage_fin(input logic [3:0] code);
    case (code)
      4'd1:    return FinHist;
      4'd2:    return FinFlv;
      4'd3:    return FinHtree;
      4'd4:    return FinCbs;
      4'd5:    return FinTrn;
      4'd6:    return FinSpi;
      default: return FinIdle;
    endcase
  endfunction

endpackage

// File: rtl/t05_stage_watchdog.sv
// Per-stage watchdog: saturating cycle counter with a fixed expiry value (0 disables).
module t05_stage_watchdog #(
  parameter int unsigned Width = 24,
  parameter int unsigned Limit = 4194304
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Limit must be representable in Width bits.
  localparam logic [Width-1:0] LimitW = Width'(Limit);
  localparam logic [Width-1:0] MaxW   = '1;

  logic [Width-1:0] count_q;

  // Count enabled cycles, holding at all-ones; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != MaxW)) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign expired = (Limit != 0) && (count_q == LimitW);

endmodule

// File: rtl/t05_stage_reporter.sv
// Stage-side end of the controller handshake: launches the active stage, collects its
// done/error pulses and reports finState/op_fin back to the controller.
module t05_stage_reporter
  import t05_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_W      = 24,
  parameter int unsigned TIMEOUT_CYCLES = 4194304
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state_reg,
  input  logic [5:0] stage_done,
  input  logic       htree_complete,
  input  logic       mod_err,
  output logic [5:0] stage_start,
  output logic [3:0] finState,
  output logic [3:0] op_fin,
  output logic       stage_busy,
  output logic       timeout,
  output logic       stray_done
);

  phase_t     phase_q;
  logic [3:0] prev_state_q;
  logic [3:0] cur_q;
  // Low for the first cycle after reset so a state_reg already non-idle at release is
  // absorbed into prev_state rather than treated as a fresh entry.
  logic       primed_q;

  logic       change;
  logic       active;
  logic [5:0] own_mask;
  logic       own_done;
  logic       stray_evt;
  logic       wd_clear;
  logic       wd_expired;

  // Event decode for the current cycle.
  always_comb begin
    change    = primed_q && (state_reg != prev_state_q);
    active    = (phase_q == PhLaunch) || (phase_q == PhRun);
    own_mask  = stage_onehot(cur_q);
    own_done  = active && (|(stage_done & own_mask));
    stray_evt = active ? (|(stage_done & ~own_mask))
                       : ((phase_q != PhErr) && (|stage_done));
    // Held at zero outside a stage; restarts on any abort/relaunch.
    wd_clear  = !active || change;
  end

  t05_stage_watchdog #(
    .Width(TIMEOUT_W),
    .Limit(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (active),
    .expired(wd_expired)
  );

  // Handshake FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q      <= PhWait;
      prev_state_q <= StateIdle;
      cur_q        <= 4'd0;
      primed_q     <= 1'b0;
      stage_start  <= '0;
      finState     <= FinIdle;
      op_fin       <= OpIdle;
      stage_busy   <= 1'b0;
      timeout      <= 1'b0;
      stray_done   <= 1'b0;
    end else begin
      prev_state_q <= state_reg;
      primed_q     <= 1'b1;
      stage_start  <= '0;
      stage_busy   <= 1'b0;

      if (state_reg == StateIdle) stray_done <= 1'b0;
      else if (stray_evt)         stray_done <= 1'b1;
      if (state_reg == StateIdle) timeout <= 1'b0;

      // A state change outside ERR drops any pending code and aborts a running stage.
      if ((phase_q != PhErr) && change) begin
        finState <= FinIdle;
        op_fin   <= OpIdle;
        if (is_stage(state_reg)) begin
          phase_q     <= PhLaunch;
          cur_q       <= state_reg;
          stage_start <= stage_onehot(state_reg);
          stage_busy  <= 1'b1;
        end else begin
          phase_q <= PhWait;
        end
      end else begin
        case (phase_q)
          PhLaunch, PhRun: begin
            if (mod_err || wd_expired) begin
              phase_q  <= PhErr;
              finState <= FinError;
              op_fin   <= OpError;
              if (wd_expired) timeout <= 1'b1;
            end else if (htree_complete && (cur_q == StateHtree)) begin
              phase_q  <= PhReport;
              finState <= FinHtreeFinished;
              op_fin   <= OpHtree;
            end else if (own_done) begin
              phase_q  <= PhReport;
              finState <= stage_fin(cur_q);
              op_fin   <= cur_q;
            end else begin
              phase_q    <= PhRun;
              stage_busy <= 1'b1;
            end
          end
          PhErr: begin
            if (state_reg == StateIdle) begin
              phase_q  <= PhWait;
              finState <= FinIdle;
              op_fin   <= OpIdle;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_t05_stage_reporter.sv
// Randomized + directed bench for t05_stage_reporter against a cycle-level reference model.
module tb_t05_stage_reporter;

  localparam int unsigned TW = 8;
  localparam int unsigned TC = 16;

  localparam int MWait = 0;
  localparam int MRun  = 1;
  localparam int MRep  = 2;
  localparam int MErr  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] state_reg;
  logic [5:0] stage_done;
  logic       htree_complete;
  logic       mod_err;
  logic [5:0] stage_start;
  logic [3:0] finState;
  logic [3:0] op_fin;
  logic       stage_busy;
  logic       timeout;
  logic       stray_done;

  always #5 clk = ~clk;

  t05_stage_reporter #(
    .TIMEOUT_W     (TW),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .state_reg     (state_reg),
    .stage_done    (stage_done),
    .htree_complete(htree_complete),
    .mod_err       (mod_err),
    .stage_start   (stage_start),
    .finState      (finState),
    .op_fin        (op_fin),
    .stage_busy    (stage_busy),
    .timeout       (timeout),
    .stray_done    (stray_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h want=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: a stage is either absent, running (with an age since launch),
  // reported, or errored. Expected outputs are what the DUT should show next cycle.
  int         m_mode;
  int         m_prev;
  int         m_stage;
  int         m_age;
  bit         m_primed;
  logic [5:0] e_start;
  logic [3:0] e_fin;
  logic [3:0] e_op;
  logic       e_busy;
  logic       e_timeout;
  logic       e_stray;
  int         fin_of [0:6] = '{0, 1, 2, 3, 5, 6, 7};

  task automatic model_reset();
    m_mode = MWait; m_prev = 0; m_stage = 0; m_age = 0; m_primed = 1'b0;
    e_start = '0; e_fin = '0; e_op = '0; e_busy = 1'b0; e_timeout = 1'b0; e_stray = 1'b0;
  endtask

  task automatic model_edge();
    int         st;
    bit         chg;
    logic [5:0] own;
    if (rst) begin
      model_reset();
      return;
    end
    st  = int'(state_reg);
    chg = m_primed && (st != m_prev);
    own = '0;
    if (m_mode == MRun) own[m_stage-1] = 1'b1;
    e_start = '0;
    if (m_mode == MRun) begin
      if ((stage_done & ~own) != 0) e_stray = 1'b1;
    end else if (m_mode != MErr && stage_done != 0) begin
      e_stray = 1'b1;
    end
    if (m_mode != MErr && chg) begin
      e_fin = '0; e_op = '0;
      if (st >= 1 && st <= 6) begin
        m_mode = MRun; m_stage = st; m_age = 0; e_start[st-1] = 1'b1;
      end else begin
        m_mode = MWait;
      end
    end else if (m_mode == MRun) begin
      if (mod_err || m_age == TC) begin
        m_mode = MErr; e_fin = 4'd8; e_op = 4'd7;
        if (m_age == TC) e_timeout = 1'b1;
      end else if (htree_complete && m_stage == 3) begin
        m_mode = MRep; e_fin = 4'd4; e_op = 4'd3;
      end else if ((stage_done & own) != 0) begin
        m_mode = MRep; e_fin = 4'(fin_of[m_stage]); e_op = 4'(m_stage);
      end else begin
        m_age++;
      end
    end else if (m_mode == MErr && st == 0) begin
      m_mode = MWait; e_fin = '0; e_op = '0;
    end
    if (st == 0) begin
      e_stray = 1'b0; e_timeout = 1'b0;
    end
    e_busy   = (m_mode == MRun);
    m_prev   = st;
    m_primed = 1'b1;
  endtask

  task automatic compare_all();
    check("start",   32'(stage_start), 32'(e_start));
    check("fin",     32'(finState),    32'(e_fin));
    check("op",      32'(op_fin),      32'(e_op));
    check("busy",    32'(stage_busy),  32'(e_busy));
    check("timeout", 32'(timeout),     32'(e_timeout));
    check("stray",   32'(stray_done),  32'(e_stray));
  endtask

  // Advance one clock: model consumes current inputs, then DUT outputs are compared.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic pulse_done(input logic [5:0] d);
    stage_done = d;
    cycle();
    stage_done = '0;
  endtask

  initial begin
    rst = 1'b1; state_reg = '0; stage_done = '0; htree_complete = 1'b0; mod_err = 1'b0;
    model_reset();
    cycle();
    cycle();
    check("rst fin", 32'(finState), 32'd0);
    rst = 1'b0;
    cycle();

    // HISTO launch, done after 5 cycles, held until FLV entered.
    state_reg = 4'd1;
    cycle();
    check("t1 start", 32'(stage_start), 32'h01);
    cycle();
    check("t1 start single", 32'(stage_start), 32'h00);
    repeat (4) cycle();
    pulse_done(6'b000001);
    check("t1 fin", 32'(finState), 32'd1);
    check("t1 op", 32'(op_fin), 32'd1);
    repeat (3) cycle();
    check("t1 fin held", 32'(finState), 32'd1);
    state_reg = 4'd2;
    cycle();
    check("t1 fin cleared", 32'(finState), 32'd0);
    check("t1 flv start", 32'(stage_start), 32'h02);

    // HTREE report, then FLV -> HTREE re-entry with htree_complete beating stage_done[2].
    state_reg = 4'd3;
    cycle();
    check("t2 start", 32'(stage_start), 32'h04);
    repeat (2) cycle();
    pulse_done(6'b000100);
    check("t2 fin", 32'(finState), 32'd3);
    state_reg = 4'd2;
    cycle();
    check("t2 reflv", 32'(stage_start), 32'h02);
    state_reg = 4'd3;
    cycle();
    check("t2 rehtree", 32'(stage_start), 32'h04);
    repeat (2) cycle();
    htree_complete = 1'b1;
    pulse_done(6'b000100);
    htree_complete = 1'b0;
    check("t2 finished", 32'(finState), 32'd4);
    check("t2 op", 32'(op_fin), 32'd3);

    // CBS: mod_err beats done; held through ERROR, cleared on IDLE.
    state_reg = 4'd4;
    cycle();
    repeat (2) cycle();
    mod_err = 1'b1;
    pulse_done(6'b001000);
    mod_err = 1'b0;
    check("t3 fin", 32'(finState), 32'd8);
    check("t3 op", 32'(op_fin), 32'd7);
    state_reg = 4'd7;
    repeat (3) cycle();
    check("t3 held", 32'(finState), 32'd8);
    state_reg = 4'd0;
    cycle();
    check("t3 clear", 32'(op_fin), 32'd0);

    // TRN watchdog expiry visible 17 cycles after LAUNCH.
    state_reg = 4'd5;
    cycle();
    repeat (16) cycle();
    check("t4 not yet", 32'(timeout), 32'd0);
    cycle();
    check("t4 timeout", 32'(timeout), 32'd1);
    check("t4 fin", 32'(finState), 32'd8);
    check("t4 op", 32'(op_fin), 32'd7);
    state_reg = 4'd0;
    cycle();
    check("t4 cleared", 32'(timeout), 32'd0);

    // Foreign done during HISTO.
    state_reg = 4'd1;
    cycle();
    cycle();
    pulse_done(6'b100000);
    check("t5 stray", 32'(stray_done), 32'd1);
    check("t5 fin", 32'(finState), 32'd0);
    state_reg = 4'd0;
    cycle();

    // Asynchronous reset mid-RUN; release with HISTO present must not launch.
    state_reg = 4'd1;
    repeat (3) cycle();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("t6 busy", 32'(stage_busy), 32'd0);
    repeat (2) cycle();
    rst = 1'b0;
    repeat (3) begin
      cycle();
      check("t6 no launch", 32'(stage_start), 32'd0);
    end
    state_reg = 4'd2;
    cycle();
    check("t6 relaunch", 32'(stage_start), 32'h02);
    state_reg = 4'd0;
    cycle();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      int r;
      if ($urandom_range(0, 14) == 0) begin
        if ($urandom_range(0, 19) == 0) state_reg = 4'($urandom_range(10, 15));
        else state_reg = 4'($urandom_range(0, 9));
      end
      r = int'($urandom_range(0, 11));
      if (r < 2) stage_done = 6'b000001 << $urandom_range(0, 5);
      else if (r == 2) stage_done = 6'($urandom);
      else if (r == 3 && m_mode == MRun) stage_done = 6'b000001 << (m_stage - 1);
      else stage_done = '0;
      htree_complete = ($urandom_range(0, 19) == 0);
      mod_err        = ($urandom_range(0, 79) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
